// File: rtl/nec_ir_pkg.sv
// Shared definitions for the NEC IR decoder: FSM states, timing windows in
// microseconds, frame field offsets and small window/checksum helpers.
package nec_ir_pkg;

    localparam int unsigned DUR_W    = 14;
    localparam int unsigned FRAME_W  = 32;
    localparam int unsigned BITCNT_W = 5;
    localparam int unsigned FIELD_W  = 8;

    // Frame field offsets (LSB of each byte)
    localparam int unsigned ADDR_LSB     = 0;
    localparam int unsigned ADDR_INV_LSB = 8;
    localparam int unsigned CMD_LSB      = 16;
    localparam int unsigned CMD_INV_LSB  = 24;

    localparam logic [DUR_W-1:0] DUR_MAX = 14'd16383;

    // Inclusive acceptance windows, microseconds
    localparam logic [DUR_W-1:0] LEAD_MARK_MIN  = 14'd8000;
    localparam logic [DUR_W-1:0] LEAD_MARK_MAX  = 14'd10000;
    localparam logic [DUR_W-1:0] LEAD_SPACE_MIN = 14'd4000;
    localparam logic [DUR_W-1:0] LEAD_SPACE_MAX = 14'd5000;
    localparam logic [DUR_W-1:0] RPT_SPACE_MIN  = 14'd2000;
    localparam logic [DUR_W-1:0] RPT_SPACE_MAX  = 14'd2500;
    localparam logic [DUR_W-1:0] BIT_MARK_MIN   = 14'd400;
    localparam logic [DUR_W-1:0] BIT_MARK_MAX   = 14'd700;
    localparam logic [DUR_W-1:0] SPACE0_MIN     = 14'd400;
    localparam logic [DUR_W-1:0] SPACE0_MAX     = 14'd700;
    localparam logic [DUR_W-1:0] SPACE1_MIN     = 14'd1400;
    localparam logic [DUR_W-1:0] SPACE1_MAX     = 14'd1900;
    localparam logic [DUR_W-1:0] STOP_MARK_MIN  = 14'd400;
    localparam logic [DUR_W-1:0] STOP_MARK_MAX  = 14'd700;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD_MARK,
        ST_LEAD_SPACE,
        ST_BIT_MARK,
        ST_BIT_SPACE,
        ST_STOP_MARK,
        ST_RPT_MARK,
        ST_ERR
    } state_t;

    function automatic logic in_window(input logic [DUR_W-1:0] dur,
                                       input logic [DUR_W-1:0] lo,
                                       input logic [DUR_W-1:0] hi);
        return (dur >= lo) && (dur <= hi);
    endfunction

    // Command byte must be the bitwise inverse of its check byte
    function automatic logic checksum_ok(input logic [FRAME_W-1:0] frame);
        return frame[CMD_LSB +: FIELD_W] == ~frame[CMD_INV_LSB +: FIELD_W];
    endfunction

    // Longest duration a state may last before it is abandoned
    function automatic logic [DUR_W-1:0] state_max(input state_t st);
        logic [DUR_W-1:0] m;
        m = DUR_MAX;
        case (st)
            ST_LEAD_MARK:  m = LEAD_MARK_MAX;
            ST_LEAD_SPACE: m = LEAD_SPACE_MAX;
            ST_BIT_MARK:   m = BIT_MARK_MAX;
            ST_BIT_SPACE:  m = SPACE1_MAX;
            ST_STOP_MARK:  m = STOP_MARK_MAX;
            ST_RPT_MARK:   m = BIT_MARK_MAX;
            default:       m = DUR_MAX;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/nec_ir_decoder_sync.sv
// Two-flop synchronizer for the raw IR line with edge pulses.
// Ports: clk, reset (sync, active-high), ir (async raw line),
//        rise_c / fall_c (combinational one-cycle edge pulses of the synced line).
module ir_input_sync (
    input  logic clk,
    input  logic reset,
    input  logic ir,
    output logic rise_c,
    output logic fall_c
);

    logic [1:0] sync;
    logic       prev;

    // Line idles high, so every flop resets to 1 to avoid a fake edge
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= 2'b11;
            prev <= 1'b1;
        end else begin
            sync <= {sync[0], ir};
            prev <= sync[1];
        end
    end

    assign rise_c = sync[1] & ~prev;
    assign fall_c = ~sync[1] & prev;

endmodule

// File: rtl/nec_ir_decoder.sv
// NEC infrared frame decoder: measures mark/space widths in microseconds,
// assembles 32-bit frames LSB first and reports frames, repeats and errors.
// Ports: iCLK clock, Reset sync active-high, iIRDA raw active-low IR line,
//        oDATA_READY / oREPEAT / oERROR one-cycle pulses, oDATA last valid frame.
// US_PER_TICK is the microseconds credited per prescaler tick (1 in silicon;
// larger values give coarse-time simulation builds).
module nec_ir_decoder
    import nec_ir_pkg::*;
#(
    parameter int unsigned CLKS_PER_US = 50,
    parameter int unsigned US_PER_TICK = 1
) (
    input  logic               iCLK,
    input  logic               Reset,
    input  logic               iIRDA,
    output logic               oDATA_READY,
    output logic [FRAME_W-1:0] oDATA,
    output logic               oREPEAT,
    output logic               oERROR
);

    localparam int unsigned PS_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(CLKS_PER_US - 1);
    localparam logic [DUR_W-1:0] DUR_STEP = DUR_W'(US_PER_TICK);

    logic                rise_c;
    logic                fall_c;
    logic                edge_c;
    logic                timeout_c;
    logic [PS_W-1:0]     ps;
    logic [DUR_W-1:0]    dur;
    state_t              state;
    logic [FRAME_W-1:0]  sr;
    logic [BITCNT_W-1:0] bitcnt;
    logic                valid_seen;

    ir_input_sync u_sync (
        .clk    (iCLK),
        .reset  (Reset),
        .ir     (iIRDA),
        .rise_c (rise_c),
        .fall_c (fall_c)
    );

    assign edge_c    = rise_c | fall_c;
    assign timeout_c = (state != ST_IDLE) && (dur > state_max(state));

    // Timebase, FSM and frame assembly; dur is compared before the edge clears it
    always_ff @(posedge iCLK) begin
        if (Reset) begin
            ps          <= '0;
            dur         <= '0;
            state       <= ST_IDLE;
            sr          <= '0;
            bitcnt      <= '0;
            valid_seen  <= 1'b0;
            oDATA       <= '0;
            oDATA_READY <= 1'b0;
            oREPEAT     <= 1'b0;
            oERROR      <= 1'b0;
        end else begin
            oDATA_READY <= 1'b0;
            oREPEAT     <= 1'b0;
            oERROR      <= 1'b0;

            if (edge_c) begin
                ps  <= '0;
                dur <= '0;
            end else if (ps == PS_LAST) begin
                ps  <= '0;
                dur <= (dur > DUR_MAX - DUR_STEP) ? DUR_MAX : dur + DUR_STEP;
            end else begin
                ps  <= ps + PS_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (fall_c) state <= ST_LEAD_MARK;
                end

                ST_LEAD_MARK: begin
                    if (rise_c) begin
                        state <= in_window(dur, LEAD_MARK_MIN, LEAD_MARK_MAX)
                                 ? ST_LEAD_SPACE : ST_IDLE;
                    end else if (timeout_c) begin
                        state <= ST_IDLE;
                    end
                end

                ST_LEAD_SPACE: begin
                    if (fall_c) begin
                        if (in_window(dur, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
                            state  <= ST_BIT_MARK;
                            bitcnt <= '0;
                        end else if (in_window(dur, RPT_SPACE_MIN, RPT_SPACE_MAX)) begin
                            state <= ST_RPT_MARK;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (timeout_c) begin
                        state <= ST_IDLE;
                    end
                end

                ST_BIT_MARK: begin
                    if (rise_c && in_window(dur, BIT_MARK_MIN, BIT_MARK_MAX)) begin
                        state <= ST_BIT_SPACE;
                    end else if (rise_c || timeout_c) begin
                        state  <= ST_ERR;
                        oERROR <= 1'b1;
                    end
                end

                ST_BIT_SPACE: begin
                    if (fall_c && (in_window(dur, SPACE0_MIN, SPACE0_MAX) ||
                                   in_window(dur, SPACE1_MIN, SPACE1_MAX))) begin
                        // LSB first: new bit enters at the top and walks down
                        sr <= {in_window(dur, SPACE1_MIN, SPACE1_MAX), sr[FRAME_W-1:1]};
                        if (bitcnt == BITCNT_W'(FRAME_W - 1)) begin
                            state <= ST_STOP_MARK;
                        end else begin
                            state  <= ST_BIT_MARK;
                            bitcnt <= bitcnt + BITCNT_W'(1);
                        end
                    end else if (fall_c || timeout_c) begin
                        state  <= ST_ERR;
                        oERROR <= 1'b1;
                    end
                end

                ST_STOP_MARK: begin
                    if (rise_c && in_window(dur, STOP_MARK_MIN, STOP_MARK_MAX)) begin
                        state <= ST_IDLE;
                        if (checksum_ok(sr)) begin
                            oDATA       <= sr;
                            oDATA_READY <= 1'b1;
                            valid_seen  <= 1'b1;
                        end else begin
                            oERROR <= 1'b1;
                        end
                    end else if (rise_c || timeout_c) begin
                        state  <= ST_ERR;
                        oERROR <= 1'b1;
                    end
                end

                ST_RPT_MARK: begin
                    if (rise_c) begin
                        state   <= ST_IDLE;
                        oREPEAT <= valid_seen && in_window(dur, BIT_MARK_MIN, BIT_MARK_MAX);
                    end else if (timeout_c) begin
                        state <= ST_IDLE;
                    end
                end

                // oERROR was raised on entry; a leader starting now is not lost
                ST_ERR: begin
                    state <= fall_c ? ST_LEAD_MARK : ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nec_ir_decoder.sv
// Self-checking bench for nec_ir_decoder using a coarse timebase (20 us per clock).
module tb_nec_ir_decoder;

    localparam int unsigned CLKS_PER_US = 1;
    localparam int unsigned US_PER_TICK = 20;

    logic        clk;
    logic        reset;
    logic        irda;
    logic        data_ready;
    logic [31:0] data;
    logic        rpt;
    logic        err;

    int errors = 0;
    int checks = 0;

    int n_ready = 0;
    int n_rpt   = 0;
    int n_err   = 0;
    int viol    = 0;
    int cyc     = 0;
    int edge_cyc = 0;
    int bad_edge_cyc = 0;
    int last_err_cyc = 0;
    logic [31:0] cap_data = '0;
    logic [31:0] prev_data = '0;
    logic        prev_pulse = 1'b0;

    // Reference model state: last accepted frame and whether one was ever seen
    logic [31:0] model_data = '0;
    bit          model_valid = 1'b0;

    nec_ir_decoder #(
        .CLKS_PER_US (CLKS_PER_US),
        .US_PER_TICK (US_PER_TICK)
    ) dut (
        .iCLK        (clk),
        .Reset       (reset),
        .iIRDA       (irda),
        .oDATA_READY (data_ready),
        .oDATA       (data),
        .oREPEAT     (rpt),
        .oERROR      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts events and notes protocol violations
    always @(negedge clk) begin
        if (reset) begin
            prev_data  = data;
            prev_pulse = 1'b0;
        end else begin
            if (int'(data_ready) + int'(rpt) + int'(err) > 1) viol++;
            if ((data_ready | rpt | err) && prev_pulse) viol++;
            if (data !== prev_data && data_ready !== 1'b1) viol++;
            if (data_ready === 1'b1) begin
                n_ready++;
                cap_data = data;
            end
            if (rpt === 1'b1) n_rpt++;
            if (err === 1'b1) begin
                n_err++;
                last_err_cyc = cyc;
            end
            prev_pulse = data_ready | rpt | err;
            prev_data  = data;
        end
    end

    function automatic bit frame_ok(input logic [31:0] f);
        return (f[23:16] ^ f[31:24]) == 8'hFF;
    endfunction

    function automatic int mark_us(input bit jit);
        return jit ? 20 * int'($urandom_range(24, 33)) : 560;
    endfunction

    function automatic int space_us(input bit one, input bit jit);
        if (one) return jit ? 20 * int'($urandom_range(74, 93)) : 1680;
        return jit ? 20 * int'($urandom_range(24, 33)) : 560;
    endfunction

    task automatic hold(input logic lvl, input int us);
        if (irda !== lvl) edge_cyc = cyc;
        irda = lvl;
        repeat (us / int'(US_PER_TICK)) @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        n_ready = 0;
        n_rpt   = 0;
        n_err   = 0;
        viol    = 0;
    endtask

    task automatic send_frame(input logic [31:0] f, input int bad_bit,
                              input bit jit, input int gap_us);
        hold(1'b0, 9000);
        hold(1'b1, 4500);
        for (int i = 0; i < 32; i++) begin
            hold(1'b0, mark_us(jit));
            if (i == bad_bit) begin
                hold(1'b1, 1000);
                hold(1'b0, 560);
                bad_edge_cyc = edge_cyc;
                hold(1'b1, gap_us);
                return;
            end
            hold(1'b1, space_us(f[i], jit));
        end
        hold(1'b0, mark_us(jit));
        hold(1'b1, gap_us);
    endtask

    task automatic send_repeat();
        hold(1'b0, 9000);
        hold(1'b1, 2240);
        hold(1'b0, 560);
        hold(1'b1, 400);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_data  = '0;
        model_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++; if (data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", data); end
        checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", data_ready); end
        checks++; if (rpt !== 1'b0) begin errors++; $display("FAIL reset_repeat: got %b want 0", rpt); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", err); end
        @(posedge clk); #1;
        hold(1'b1, 400);
        clear_counts();
        send_repeat();
        checks++; if (n_rpt + n_ready + n_err !== 0) begin errors++; $display("FAIL repeat_no_frame: got %0d pulses want 0", n_rpt + n_ready + n_err); end
    endtask

    task automatic test_frame();
        clear_counts();
        send_frame(32'hE916FF00, -1, 1'b0, 400);
        model_data = 32'hE916FF00; model_valid = 1'b1;
        checks++; if (n_ready !== 1) begin errors++; $display("FAIL frame_ready: got %0d want 1", n_ready); end
        checks++; if (n_err !== 0) begin errors++; $display("FAIL frame_error: got %0d want 0", n_err); end
        checks++; if (data !== model_data) begin errors++; $display("FAIL frame_data: got %h want %h", data, model_data); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL frame_protocol: got %0d violations want 0", viol); end
    endtask

    task automatic test_repeat();
        clear_counts();
        send_repeat();
        checks++; if (n_rpt !== 1) begin errors++; $display("FAIL repeat_pulse: got %0d want 1", n_rpt); end
        checks++; if (n_ready + n_err !== 0) begin errors++; $display("FAIL repeat_other: got %0d want 0", n_ready + n_err); end
        checks++; if (data !== model_data) begin errors++; $display("FAIL repeat_data: got %h want %h", data, model_data); end
    endtask

    task automatic test_bad_checksum();
        clear_counts();
        send_frame(32'h1616FF00, -1, 1'b0, 400);
        checks++; if (n_err !== 1) begin errors++; $display("FAIL cksum_error: got %0d want 1", n_err); end
        checks++; if (n_ready !== 0) begin errors++; $display("FAIL cksum_ready: got %0d want 0", n_ready); end
        checks++; if (data !== model_data) begin errors++; $display("FAIL cksum_data: got %h want %h", data, model_data); end
    endtask

    task automatic test_bit_error();
        clear_counts();
        send_frame(32'h40BF2C2C, 10, 1'b0, 400);
        checks++; if (n_err !== 1) begin errors++; $display("FAIL biterr_error: got %0d want 1", n_err); end
        checks++; if (last_err_cyc - bad_edge_cyc !== 3) begin errors++; $display("FAIL biterr_latency: got %0d want 3", last_err_cyc - bad_edge_cyc); end
        checks++; if (data !== model_data) begin errors++; $display("FAIL biterr_data: got %h want %h", data, model_data); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL biterr_protocol: got %0d violations want 0", viol); end
        clear_counts();
        send_frame(32'h40BF2C2C, -1, 1'b0, 400);
        model_data = 32'h40BF2C2C;
        checks++; if (n_ready !== 1 || n_err !== 0) begin errors++; $display("FAIL biterr_recover: got ready=%0d err=%0d want 1/0", n_ready, n_err); end
        checks++; if (data !== model_data) begin errors++; $display("FAIL biterr_recover_data: got %h want %h", data, model_data); end
    endtask

    task automatic test_bad_leader();
        clear_counts();
        hold(1'b0, 7000);
        hold(1'b1, 4500);
        hold(1'b0, 20000);
        hold(1'b1, 2000);
        checks++; if (n_ready + n_rpt + n_err !== 0) begin errors++; $display("FAIL leader_pulses: got %0d want 0", n_ready + n_rpt + n_err); end
        send_frame(32'hF20D7788, -1, 1'b0, 400);
        model_data = 32'hF20D7788;
        checks++; if (n_ready !== 1 || data !== model_data) begin errors++; $display("FAIL leader_recover: got ready=%0d data=%h want 1/%h", n_ready, data, model_data); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] f;
        f = 32'h9E61A55A;
        clear_counts();
        hold(1'b0, 9000);
        hold(1'b1, 4500);
        for (int i = 0; i < 20; i++) begin
            hold(1'b0, 560);
            hold(1'b1, space_us(f[i], 1'b0));
        end
        hold(1'b0, 280);
        apply_reset();
        @(negedge clk);
        checks++; if ({data_ready, rpt, err} !== 3'b000 || data !== 32'h0) begin errors++; $display("FAIL midreset_outputs: got %b/%h want 000/0", {data_ready, rpt, err}, data); end
        @(posedge clk); #1;
        hold(1'b0, 280);
        hold(1'b1, 2000);
        send_repeat();
        checks++; if (n_ready + n_rpt + n_err !== 0) begin errors++; $display("FAIL midreset_pulses: got %0d want 0", n_ready + n_rpt + n_err); end
        send_frame(f, -1, 1'b0, 400);
        model_data = f; model_valid = 1'b1;
        checks++; if (n_ready !== 1 || data !== model_data) begin errors++; $display("FAIL midreset_frame: got ready=%0d data=%h want 1/%h", n_ready, data, model_data); end
    endtask

    task automatic test_back_to_back();
        clear_counts();
        send_frame(32'h7F80C03C, -1, 1'b0, 80);
        send_frame(32'hB748E11E, -1, 1'b0, 400);
        model_data = 32'hB748E11E;
        checks++; if (n_ready !== 2) begin errors++; $display("FAIL b2b_ready: got %0d want 2", n_ready); end
        checks++; if (data !== model_data) begin errors++; $display("FAIL b2b_data: got %h want %h", data, model_data); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL b2b_protocol: got %0d violations want 0", viol); end
    endtask

    task automatic test_random();
        logic [31:0] f;
        bit ok;
        for (int k = 0; k < 4; k++) begin
            f = $urandom;
            if ($urandom_range(0, 3) != 0) f[31:24] = ~f[23:16];
            else if (frame_ok(f)) f[31:24] = f[31:24] ^ 8'h01;
            ok = frame_ok(f);
            clear_counts();
            send_frame(f, -1, 1'b1, 400);
            if (ok) begin model_data = f; model_valid = 1'b1; end
            checks++; if (n_ready !== int'(ok) || n_err !== int'(!ok)) begin errors++; $display("FAIL rand_frame%0d: got ready=%0d err=%0d for %h", k, n_ready, n_err, f); end
            checks++; if (data !== model_data) begin errors++; $display("FAIL rand_data%0d: got %h want %h", k, data, model_data); end
            if ($urandom_range(0, 1) == 1) begin
                clear_counts();
                send_repeat();
                checks++; if (n_rpt !== int'(model_valid)) begin errors++; $display("FAIL rand_repeat%0d: got %0d want %0d", k, n_rpt, int'(model_valid)); end
            end
            checks++; if (viol !== 0) begin errors++; $display("FAIL rand_protocol%0d: got %0d violations want 0", k, viol); end
        end
    endtask

    initial begin
        reset = 1'b1;
        irda  = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_frame();
        test_repeat();
        test_bad_checksum();
        test_bit_error();
        test_bad_leader();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nec_ir_decoder.md
# nec_ir_decoder

Front-end NEC infrared frame decoder for the IrDA port. Samples the demodulated IR receiver output (`iIRDA`, active-low bursts) on the 50 MHz clock and measures mark/space widths in microseconds. Assembles the 32-bit NEC frame and delivers it with a one-cycle ready pulse to the memory-mapped IrDA bus interface directly downstream. Also flags repeat codes and malformed frames.

## Interface
- `CLKS_PER_US`, 50, clock cycles per microsecond tick (sim benches may use 2).
- `iCLK`  in  1  system clock, 50 MHz.
- `Reset`  in  1  synchronous, active-high reset.
- `iIRDA`  in  1  raw IR receiver output; idle high, low during carrier burst; asynchronous.
- `oDATA_READY`  out  1  one-cycle pulse: `oDATA` just updated with a valid frame.
- `oDATA`  out  32  last valid frame; [7:0] address, [15:8] address-inverse/extended address, [23:16] command, [31:24] ~command.
- `oREPEAT`  out  1  one-cycle pulse: valid repeat code received after at least one valid frame.
- `oERROR`  out  1  one-cycle pulse: frame aborted after an accepted leader, or checksum fail.

One clock; reset is synchronous and active-high.

## Operation
- Input: 2-flop synchronizer, both flops reset to 1; edge detect on synced value.
- Timebase: prescaler 0..CLKS_PER_US-1 emits a µs tick; 14-bit duration counter increments per tick, saturates at 16383. Both clear on every synced edge, after the edge comparison.
- Windows (µs, inclusive): LEAD_MARK 8000–10000; LEAD_SPACE 4000–5000; RPT_SPACE 2000–2500; BIT_MARK 400–700; SPACE0 400–700; SPACE1 1400–1900; STOP_MARK 400–700.
- FSM:
  - IDLE: falling edge -> LEAD_MARK.
  - LEAD_MARK: rising edge in window -> LEAD_SPACE, else IDLE (no error).
  - LEAD_SPACE: falling edge in LEAD_SPACE window -> BIT_MARK, bitcnt=0. In RPT_SPACE window -> RPT_MARK. Else IDLE (no error).
  - BIT_MARK: rising edge in window -> BIT_SPACE; else ERR.
  - BIT_SPACE: falling edge in SPACE0 shifts in 0, SPACE1 shifts in 1, else ERR. LSB first: shift register right-shifts, new bit into [31]. After the 32nd bit -> STOP_MARK, else BIT_MARK and bitcnt++.
  - STOP_MARK: rising edge in window -> check `sr[23:16] == ~sr[31:24]`. Pass: oDATA<=sr, oDATA_READY, valid_seen<=1 -> IDLE. Fail: oERROR -> IDLE. Out-of-window edge -> ERR.
  - RPT_MARK: rising edge in window -> oREPEAT if valid_seen -> IDLE. Otherwise -> IDLE silently.
  - ERR: pulse oERROR one cycle -> IDLE.
- Timeout: in any non-IDLE state, counter exceeding the current state's window maximum aborts without waiting for the edge. Goes to ERR from BIT_*/STOP_MARK, to IDLE otherwise.
- Address byte not checked (extended NEC allowed).
- oDATA retained across errors and repeats.

## Timing
- Reset values: oDATA=0, oDATA_READY=0, oREPEAT=0, oERROR=0, FSM=IDLE, valid_seen=0, counters=0.
- Reset mid-frame: frame discarded, no pulses, valid_seen cleared.
- Latency: oDATA_READY/oREPEAT/oERROR assert in the cycle after the synced edge (or timeout) is detected, 3 cycles after the raw `iIRDA` edge. Each is high exactly one cycle.
- oDATA changes only in the oDATA_READY cycle.
- At most one of the three pulses is high in any cycle.
- A new leader accepted in the cycle after any pulse; back-to-back frames need no gap beyond the protocol's.
- Window compares use the µs count at edge time; quantization ±1 µs is acceptable.

## Structure
- Package `nec_ir_pkg`: FSM state enum, window constants (µs), frame field offsets.
- Sub-module `ir_input_sync`: 2-flop sync plus rise/fall pulse outputs, reset-to-high.
- Decoder holds prescaler, duration counter, FSM, 32-bit shift register, 5-bit bitcnt.

## Test plan
- Frame addr 0x00, cmd 0x16 (oDATA 0xE916FF00) -> single oDATA_READY, oDATA=0xE916FF00, no oERROR.
- Same frame then repeat code (9000/2250/560) -> oREPEAT once, oDATA unchanged. Repeat after reset with no prior frame -> no pulses.
- Frame with cmd inverse corrupted (0x16/0x16) -> oERROR once, oDATA keeps previous value.
- Bit 10 space 1000 µs -> oERROR one cycle after that edge; a following valid frame 0x40BF2C2C still decodes.
- Leader mark 7000 µs or line held low 20 ms -> no pulses, FSM back to IDLE. Reset asserted mid-bit 20 -> all outputs 0; the next full frame decodes correctly.
